// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and drives the IF/ID register.
// Latency: IF/ID loads on the edge that samples imem_ack, so a 0-wait memory sustains one instruction per cycle.
// Backpressure: a decode freeze holds IF/ID, parks one early-returning word in a buffer and stops requesting.
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,           // asynchronous, active low
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [31:0]       Ins,
  output logic              valid
);

  // REQ   : a request is (or is about to be) outstanding for r_req_addr
  // DRAIN : a redirect arrived while a request was outstanding; wait out its ack and drop the data
  // STALL : decode is frozen and one fetched word waits in r_buf; no request is issued
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Held low through the first cycle after reset release so the first request starts one cycle later.
  logic              r_active;

  logic [ADDR_W-1:0] r_pc;          // next address to fetch
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_addr;    // address of the current request, frozen while imem_req=1
  logic [31:0]       r_buf;         // word fetched while decode was frozen
  logic [31:0]       w_buf_nxt;

  logic [ADDR_W-1:0] r_id_pc;
  logic [31:0]       r_id_ins;
  logic              r_id_vld;
  logic [ADDR_W-1:0] w_id_pc_nxt;
  logic [31:0]       w_id_ins_nxt;
  logic              w_id_vld_nxt;

  logic              w_ack;         // ack qualified by an outstanding request
  logic              w_new_req;     // a fresh request begins next cycle
  logic              w_load;        // a real instruction is ready for IF/ID this cycle
  logic [ADDR_W-1:0] w_load_pc;
  logic [31:0]       w_load_ins;
  logic [ADDR_W-1:0] w_br_tgt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_req_inc;

  assign imem_req  = r_active && (r_state != S_STALL);
  assign imem_addr = r_req_addr;
  assign w_ack     = imem_ack && imem_req;

  // Branch targets are word aligned; sums wrap naturally at ADDR_W bits.
  assign w_br_tgt  = branch_addr & ~ADDR_W'(3);
  assign w_pc_inc  = r_pc + ADDR_W'(4);
  assign w_req_inc = r_req_addr + ADDR_W'(4);

  assign PC    = r_id_pc;
  assign Ins   = r_id_ins;
  assign valid = r_id_vld;

  // Next-state, next-pc, buffer and IF/ID load selection
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_load      = 1'b0;
    w_load_pc   = '0;
    w_load_ins  = '0;

    if (!r_active) begin
      // Nothing outstanding yet; a redirect just moves where the first fetch goes.
      if (branch_taken) begin
        w_pc_nxt = w_br_tgt;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_ack) begin
            if (branch_taken) begin
              // Returned word is on the wrong path: drop it and refetch at the target.
              w_pc_nxt = w_br_tgt;
            end else if (!freeze || !r_id_vld) begin
              w_load     = 1'b1;
              w_load_pc  = w_req_inc;
              w_load_ins = imem_rdata;
              w_pc_nxt   = w_pc_inc;
            end else begin
              // Decode cannot take it yet; park the word and stop fetching.
              w_buf_nxt   = imem_rdata;
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = S_STALL;
            end
          end else if (branch_taken) begin
            // The outstanding request must complete before the target can be fetched.
            w_pc_nxt    = w_br_tgt;
            w_state_nxt = S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (branch_taken) begin
            w_pc_nxt = w_br_tgt;
          end
          if (w_ack) begin
            w_state_nxt = S_REQ;
          end
        end

        S_STALL: begin
          if (branch_taken) begin
            w_buf_nxt   = '0;
            w_pc_nxt    = w_br_tgt;
            w_state_nxt = S_REQ;
          end else if (!freeze) begin
            // pc already points past the parked word, so it is that word's PC+4.
            w_load      = 1'b1;
            w_load_pc   = r_pc;
            w_load_ins  = r_buf;
            w_buf_nxt   = '0;
            w_state_nxt = S_REQ;
          end
        end

        default: begin
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  // A request starts next cycle when we land in REQ with nothing still outstanding
  assign w_new_req = (w_state_nxt == S_REQ) && (!imem_req || w_ack);

  // IF/ID next value: flush > hold on freeze > load > bubble
  always_comb begin
    w_id_pc_nxt  = r_id_pc;
    w_id_ins_nxt = '0;
    w_id_vld_nxt = 1'b0;
    if (branch_taken) begin
      w_id_pc_nxt  = '0;
    end else if (freeze && r_id_vld) begin
      w_id_ins_nxt = r_id_ins;
      w_id_vld_nxt = 1'b1;
    end else if (w_load) begin
      w_id_pc_nxt  = w_load_pc;
      w_id_ins_nxt = w_load_ins;
      w_id_vld_nxt = 1'b1;
    end
  end

  // Fetch control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_active   <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_buf      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= 1'b1;
      r_pc     <= w_pc_nxt;
      r_buf    <= w_buf_nxt;
      if (w_new_req) begin
        r_req_addr <= w_pc_nxt;
      end
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_pc  <= '0;
      r_id_ins <= '0;
      r_id_vld <= 1'b0;
    end else begin
      r_id_pc  <= w_id_pc_nxt;
      r_id_ins <= w_id_ins_nxt;
      r_id_vld <= w_id_vld_nxt;
    end
  end

  // A pending request stays up with a stable address until acknowledged
  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  // Bubbles always carry a zero instruction word
  a_bubble_zero: assert property (@(posedge clk) disable iff (!rst)
    !valid |-> (Ins == 32'h0));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a programmable-latency instruction memory.
// Latency: memory acks after lat wait cycles (lat=0 acks in the request's first cycle).
// Backpressure: freeze and branch_taken are driven directly from the stimulus sequence.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Ins;
  logic        valid;

  int n_tests;
  int n_fail;

  logic [1:0] lat;
  logic [1:0] cnt;

  if_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .PC           (PC),
    .Ins          (Ins),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word stored at a given address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1300_0000 ^ a;
  endfunction

  // Count cycles a request has waited; ack once lat wait cycles have passed
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 2'd0;
    else if (imem_req && !imem_ack) cnt <= cnt + 2'd1;
    else cnt <= 2'd0;
  end

  assign imem_ack   = imem_req && (cnt == lat);
  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where rst has just been released
  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
    chk({tag, "_ins"}, Ins, ins);
    chk({tag, "_pc"}, PC, pc);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    lat          = 2'd0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk_ifid("rst", 1'b0, 32'h0, 32'h0);

    // Zero-latency memory: one instruction per cycle
    rst = 1'b1;
    chk("rel_req_low", {31'b0, imem_req}, 32'd0);
    step();
    chk("z_first_req", {31'b0, imem_req}, 32'd1);
    chk("z_first_addr", imem_addr, 32'h0);
    chk("z_first_vld", {31'b0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_ifid("z_stream", 1'b1, mem_word(32'(4 * i)), 32'(4 * i + 4));
      chk("z_addr", imem_addr, 32'(4 * i + 4));
    end

    // Two-cycle memory: bubbles between instructions
    lat = 2'd1;
    do_reset();
    step();
    chk("l2_req_a", {31'b0, imem_req}, 32'd1);
    chk("l2_addr_a", imem_addr, 32'h0);
    chk("l2_ack_a", {31'b0, imem_ack}, 32'd0);
    step();
    chk("l2_addr_b", imem_addr, 32'h0);
    chk("l2_ack_b", {31'b0, imem_ack}, 32'd1);
    chk("l2_vld_b", {31'b0, valid}, 32'd0);
    step();
    chk_ifid("l2_c", 1'b1, mem_word(32'h0), 32'h4);
    chk("l2_addr_c", imem_addr, 32'h4);
    step();
    chk_ifid("l2_d", 1'b0, 32'h0, 32'h4);
    step();
    chk_ifid("l2_e", 1'b1, mem_word(32'h4), 32'h8);

    // Freeze for three cycles while a word returns
    lat = 2'd0;
    do_reset();
    step();
    step();
    chk_ifid("fz_pre", 1'b1, mem_word(32'h0), 32'h4);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fz_req", {31'b0, imem_req}, 32'd0);
      chk_ifid("fz_hold", 1'b1, mem_word(32'h0), 32'h4);
    end
    freeze = 1'b0;
    step();
    chk_ifid("fz_buf", 1'b1, mem_word(32'h4), 32'h8);
    chk("fz_req_addr", imem_addr, 32'h8);
    step();
    chk_ifid("fz_next", 1'b1, mem_word(32'h8), 32'hC);

    // Branch while a three-cycle fetch of 0x8 is pending
    lat = 2'd2;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    chk_ifid("br_pre", 1'b1, mem_word(32'h4), 32'h8);
    chk("br_pre_addr", imem_addr, 32'h8);
    branch_taken = 1'b1;
    branch_addr  = 32'h103;
    step();
    branch_taken = 1'b0;
    chk_ifid("br_flush", 1'b0, 32'h0, 32'h0);
    chk("br_drain_req", {31'b0, imem_req}, 32'd1);
    chk("br_drain_addr", imem_addr, 32'h8);
    step();
    chk("br_drain_ack", {31'b0, imem_ack}, 32'd1);
    step();
    chk("br_new_addr", imem_addr, 32'h100);
    chk_ifid("br_dropped", 1'b0, 32'h0, 32'h0);
    step();
    step();
    step();
    chk_ifid("br_target", 1'b1, mem_word(32'h100), 32'h104);

    // Branch arriving in STALL with freeze still high
    lat = 2'd0;
    do_reset();
    step();
    step();
    freeze = 1'b1;
    step();
    chk("st_req", {31'b0, imem_req}, 32'd0);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    branch_taken = 1'b0;
    freeze       = 1'b0;
    chk_ifid("st_flush", 1'b0, 32'h0, 32'h0);
    chk("st_req_addr", imem_addr, 32'h200);
    chk("st_req_on", {31'b0, imem_req}, 32'd1);
    step();
    chk_ifid("st_target", 1'b1, mem_word(32'h200), 32'h204);

    // Reset pulled low mid-request
    lat = 2'd2;
    rst = 1'b0;
    #1;
    chk("mr_req", {31'b0, imem_req}, 32'd0);
    chk_ifid("mr", 1'b0, 32'h0, 32'h0);
    step();
    rst = 1'b1;
    step();
    chk("mr_restart_addr", imem_addr, 32'h0);
    chk("mr_restart_req", {31'b0, imem_req}, 32'd1);
    step();
    step();
    step();
    chk_ifid("mr_first", 1'b1, mem_word(32'h0), 32'h4);

    // Branch coinciding with an ack, target wraps past the top of memory
    lat = 2'd0;
    do_reset();
    step();
    step();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFF;
    step();
    branch_taken = 1'b0;
    chk_ifid("wr_flush", 1'b0, 32'h0, 32'h0);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk_ifid("wr_wrap", 1'b1, mem_word(32'hFFFF_FFFC), 32'h0);
    chk("wr_next_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
